// File: rtl/audio_gain_pwm_out.sv
// audio_gain_pwm_out: per-channel gain ramp with soft mute, error-feedback requantiser and PWM drive.
module audio_gain_pwm_out #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 16,
    parameter int PWM_W     = 7,
    parameter int RAMP_STEP = 64
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Sample_Strobe,
    input  logic                         PWM_Strobe,
    input  logic [CHANNELS*SAMPLE_W-1:0] Audio,
    input  logic [CHANNELS*GAIN_W-1:0]   Gain,
    input  logic                         Mute,
    input  logic                         Enable,
    output logic [CHANNELS-1:0]          PWM_Out,
    output logic [CHANNELS*PWM_W-1:0]    Level,
    output logic                         Ramp_Busy
);
    localparam int EW = SAMPLE_W - PWM_W;
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);
    localparam logic [PWM_W-1:0] MID = {1'b1, {(PWM_W-1){1'b0}}};

    logic [PWM_W:0]      cnt;
    logic [CHANNELS-1:0] busy;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) cnt <= '1;
        else if (PWM_Strobe) cnt <= '0;
        else if (cnt != '1) cnt <= cnt + 1'b1;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) Ramp_Busy <= 1'b0;
        else Ramp_Busy <= |busy;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [GAIN_W-1:0]              tgt, g_eff, g_next, up, dn;
        logic signed [SAMPLE_W-1:0]     smp, scaled, sc_next;
        logic signed [SAMPLE_W+GAIN_W:0] prod;
        logic [SAMPLE_W:0]              acc;
        logic [EW-1:0]                  err;
        logic [PWM_W-1:0]               lvl;
        logic                           pwm;

        always_comb begin
            tgt     = (Mute || !Enable) ? '0 : Gain[c*GAIN_W +: GAIN_W];
            up      = tgt - g_eff;
            dn      = g_eff - tgt;
            g_next  = (tgt > g_eff) ? ((up > STEP) ? g_eff + STEP : tgt)
                                    : ((dn > STEP) ? g_eff - STEP : tgt);
            prod    = smp * $signed({1'b0, g_eff});
            sc_next = SAMPLE_W'(prod >>> GAIN_W);
            // offset-binary sample plus the residue left over from the previous period
            acc     = {1'b0, ~scaled[SAMPLE_W-1], scaled[SAMPLE_W-2:0]} + {{(PWM_W+1){1'b0}}, err};
        end

        always_ff @(posedge Clk or posedge Reset)
            if (Reset) begin
                g_eff  <= '0;
                smp    <= '0;
                scaled <= '0;
                err    <= '0;
                lvl    <= MID;
                pwm    <= 1'b0;
            end else begin
                if (!Enable) g_eff <= '0;
                else if (Sample_Strobe) g_eff <= g_next;
                if (Sample_Strobe) smp <= Audio[c*SAMPLE_W +: SAMPLE_W];
                scaled <= sc_next;
                if (!Enable) begin
                    err <= '0;
                    lvl <= MID;
                end else if (PWM_Strobe) begin
                    lvl <= acc[SAMPLE_W] ? '1 : acc[SAMPLE_W-1 -: PWM_W];
                    err <= acc[SAMPLE_W] ? '0 : acc[EW-1:0];
                end
                pwm <= Enable && ({1'b0, lvl} > cnt);
            end

        assign busy[c]                   = g_eff != tgt;
        assign Level[c*PWM_W +: PWM_W]   = lvl;
        assign PWM_Out[c]                = pwm;
    end
endmodule

// File: tb/tb_audio_gain_pwm_out.sv
// tb_audio_gain_pwm_out: directed scenarios plus random traffic against an arithmetic reference model.
module tb_audio_gain_pwm_out;
    localparam int CH = 2, SW = 16, GW = 16, PW = 7;
    localparam logic [CH*PW-1:0] MIDS = {7'd64, 7'd64};

    logic Clk = 0, Reset = 1, Sample_Strobe = 0, PWM_Strobe = 0, Mute = 0, Enable = 0;
    logic [CH*SW-1:0] Audio = '0;
    logic [CH*GW-1:0] Gain = '0;
    logic [CH-1:0]    PWM_Out;
    logic [CH*PW-1:0] Level;
    logic             Ramp_Busy;

    int errors = 0, checks = 0;
    bit chk_on = 0, run = 0, rnd = 0;
    int sp = 4, pp = 130;

    always #5 Clk = ~Clk;

    audio_gain_pwm_out dut (
        .Clk(Clk), .Reset(Reset), .Sample_Strobe(Sample_Strobe), .PWM_Strobe(PWM_Strobe),
        .Audio(Audio), .Gain(Gain), .Mute(Mute), .Enable(Enable),
        .PWM_Out(PWM_Out), .Level(Level), .Ramp_Busy(Ramp_Busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: gain, sample, scaled value, residue and duty per channel as plain integers
    int g[CH], s[CH], sc[CH], e[CH], lv[CH], t[CH], k, a;
    bit pw[CH], bz;
    logic [CH-1:0]    m_pwm = '0;
    logic [CH*PW-1:0] m_lvl = MIDS;
    logic             m_busy = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            k = 255; bz = 0;
            for (int c = 0; c < CH; c++) begin
                g[c] = 0; s[c] = 0; sc[c] = 0; e[c] = 0; lv[c] = 64; pw[c] = 0;
            end
        end else begin
            bz = 0;
            for (int c = 0; c < CH; c++) begin
                t[c] = (Mute || !Enable) ? 0 : int'(Gain[c*GW +: GW]);
                pw[c] = Enable && (lv[c] > k);
                bz |= (g[c] != t[c]);
                if (!Enable) begin
                    e[c] = 0; lv[c] = 64;
                end else if (PWM_Strobe) begin
                    a = sc[c] + 32768 + e[c];
                    if (a >= 65536) begin lv[c] = 127; e[c] = 0; end
                    else begin lv[c] = a / 512; e[c] = a % 512; end
                end
                sc[c] = int'((longint'(s[c]) * longint'(g[c])) >>> 16);
                if (!Enable) g[c] = 0;
                else if (Sample_Strobe)
                    g[c] += (t[c] - g[c] > 64) ? 64 : (t[c] - g[c] < -64) ? -64 : t[c] - g[c];
                if (Sample_Strobe) s[c] = int'($signed(Audio[c*SW +: SW]));
            end
            k = PWM_Strobe ? 0 : (k < 255 ? k + 1 : 255);
        end
        for (int c = 0; c < CH; c++) begin
            m_pwm[c] = pw[c];
            m_lvl[c*PW +: PW] = PW'(lv[c]);
        end
        m_busy = bz;
    end

    always @(negedge Clk)
        if (chk_on) begin
            check("pwm_out", 32'(PWM_Out), 32'(m_pwm));
            check("level", 32'(Level), 32'(m_lvl));
            check("ramp_busy", 32'(Ramp_Busy), 32'(m_busy));
        end

    initial begin
        int scn = 0, pcn = 0;
        forever begin
            @(posedge Clk);
            #1;
            if (!run) begin
                Sample_Strobe = 0; PWM_Strobe = 0; scn = 0; pcn = 0;
            end else begin
                Sample_Strobe = rnd ? ($urandom_range(0, 5) == 0) : (scn == 0);
                PWM_Strobe = (pcn == 0);
                scn = (scn + 1) % sp;
                pcn = (pcn + 1) % pp;
            end
        end
    end

    task automatic ramp(input bit m, input bit en, output int n);
        int w = 0;
        n = 0;
        run = 0;
        repeat (2) @(negedge Clk);
        Mute = m; Enable = en;
        while (Ramp_Busy !== 1'b1 && w < 50) begin @(negedge Clk); w++; end
        run = 1; w = 0;
        while (Ramp_Busy !== 1'b0 && w < 20000) begin
            @(negedge Clk);
            if (Sample_Strobe) n++;
            w++;
        end
    endtask

    task automatic measure(input int ch, output int l, output int hi, output int first);
        int w = 0;
        hi = 0; first = -1; l = -1;
        while (PWM_Strobe !== 1'b1 && w < 1000) begin @(negedge Clk); w++; end
        for (int i = 1; i <= 130; i++) begin
            @(negedge Clk);
            if (i == 1) l = int'(Level[ch*PW +: PW]);
            if (PWM_Out[ch] === 1'b1) begin hi++; if (first < 0) first = i; end
        end
    endtask

    initial begin
        int n, l, hi, first, l2, hi2, n127;
        Gain = {16'hFFFF, 16'hFFFF};
        Enable = 1;
        @(posedge Clk);
        chk_on = 1;
        @(negedge Clk);
        check("reset_level", 32'(Level), 32'(MIDS));
        check("reset_pwm", 32'(PWM_Out), 0);
        check("reset_busy", 32'(Ramp_Busy), 0);
        Reset = 0;
        ramp(0, 1, n);
        check("ramp_up_strobes", n, 1024);

        Audio = 32'h1234_5678;
        ramp(1, 1, n);
        check("mute_down_strobes", n, 1024);
        repeat (300) @(negedge Clk);
        measure(0, l, hi, first);
        check("mute_level", l, 64);
        check("mute_high_cycles", hi, 64);
        check("mute_first_high", first, 2);

        Audio = {16'h7FFF, 16'h7FFF};
        ramp(0, 1, n);
        check("reramp_strobes", n, 1024);
        repeat (300) @(negedge Clk);
        n127 = 0;
        for (int i = 0; i < 6; i++) begin
            measure(1, l, hi, first);
            if (l == 127 && hi == 127) n127++;
        end
        check("pos_full_scale_periods", n127, 6);
        Audio = {16'h8000, 16'h8000};
        repeat (300) @(negedge Clk);
        measure(0, l, hi, first);
        check("neg_full_scale_level", l, 0);
        check("neg_full_scale_high", hi, 0);

        Audio = {16'h0101, 16'h0101};
        repeat (300) @(negedge Clk);
        measure(0, l, hi, first);
        measure(0, l2, hi2, first);
        check("dither_sum", l + l2, 129);
        check("dither_high_sum", hi + hi2, 129);
        check("dither_alternates", (l == 64 || l == 65) && l != l2, 1);

        Audio = {16'h9400, 16'h9400};
        repeat (300) @(negedge Clk);
        measure(0, l, hi, first);
        check("level10", l, 10);
        check("level10_high", hi, 10);
        check("level10_first", first, 2);
        n = 0;
        while (PWM_Strobe !== 1'b1 && n < 1000) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        Enable = 0;
        @(negedge Clk);
        check("disable_pwm", 32'(PWM_Out), 0);
        check("disable_level", 32'(Level), 32'(MIDS));
        ramp(0, 1, n);
        check("reenable_strobes", n, 1024);

        repeat (300) @(negedge Clk);
        n = 0;
        while (PWM_Strobe !== 1'b1 && n < 1000) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        #2;
        check("pre_reset_pwm_high", 32'(PWM_Out[0]), 1);
        Reset = 1;
        #1;
        check("async_reset_pwm", 32'(PWM_Out), 0);
        check("async_reset_level", 32'(Level), 32'(MIDS));
        check("async_reset_busy", 32'(Ramp_Busy), 0);
        repeat (3) @(negedge Clk);
        run = 0;
        Reset = 0;
        ramp(0, 1, n);
        check("post_reset_strobes", n, 1024);

        rnd = 1;
        run = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge Clk);
            if ($urandom_range(0, 3) == 0) Audio = $urandom;
            if ($urandom_range(0, 199) == 0) Gain = {16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 499) == 0) Mute = ~Mute;
            if ($urandom_range(0, 999) == 0) Enable = ~Enable;
        end
        @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
